// File: rtl/multi_digit_integer_display_controller.sv
// Sequential double-dabble integer-to-BCD converter feeding a multiplexed seven-segment bank.
// Build option SIGNED_DISPLAY_EN: two's-complement input, magnitude conversion and minus-sign rendering.
module multi_digit_integer_display_controller #(
  parameter int unsigned BINARY_WIDTH       = 8,
  parameter int unsigned NUM_DIGITS         = 3,
  parameter int unsigned SCAN_DIVIDER       = 50000,
  parameter int unsigned ACTIVE_LOW_OUTPUTS = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BINARY_WIDTH-1:0]   display_integer,
  input  logic                      load,
  output logic                      busy,
  output logic [4*NUM_DIGITS-1:0]   bcd_data,
  output logic                      overflow,
  output logic [7:0]                segment_bits,
  output logic [NUM_DIGITS-1:0]     digit_enable,
  output logic                      digit_change_tick
);

  localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = $clog2(BINARY_WIDTH + 1);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIVIDER);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [7:0]            SEG_IDLE = (ACTIVE_LOW_OUTPUTS != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] EN_IDLE  = (ACTIVE_LOW_OUTPUTS != 0) ? {NUM_DIGITS{1'b1}}
                                                                         : {NUM_DIGITS{1'b0}};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  logic [1:0]              state;
  logic [BINARY_WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0]        work_bcd;
  logic                    work_ovf;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    pending_valid;
  logic [BINARY_WIDTH-1:0] pending_value;

  logic                    start;
  logic [BINARY_WIDTH-1:0] capture_raw;
  logic [BINARY_WIDTH-1:0] capture_mag;
  logic [BCD_W-1:0]        adj_bcd;
  logic                    commit_now;
  logic                    commit_ovf;
  logic [BCD_W-1:0]        bcd_next;
  logic                    ovf_next;
`ifdef SIGNED_DISPLAY_EN
  logic                    capture_neg;
  logic                    work_neg;
  logic                    neg_reg;
  logic                    neg_next;
`endif

  logic [SCAN_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic [IDX_W-1:0]        scan_idx_next;
  logic                    scan_wrap;
  logic [7:0]              glyph;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              sel_digit;
  int unsigned             sel_pos;
  int unsigned             msd_pos;

  function automatic logic [7:0] seven_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  assign busy       = (state != ST_IDLE);
  assign commit_now = (state == ST_COMMIT);

  // A load arriving in the commit cycle is newer than anything pending, so it wins.
  assign start       = ((state == ST_IDLE) && load) ||
                       (commit_now && (load || pending_valid));
  assign capture_raw = (commit_now && !load) ? pending_value : display_integer;

`ifdef SIGNED_DISPLAY_EN
  assign capture_neg = capture_raw[BINARY_WIDTH-1];
  assign capture_mag = capture_neg ? (~capture_raw + BINARY_WIDTH'(1)) : capture_raw;
  // Negative values give up the top digit to the minus sign.
  assign commit_ovf  = work_ovf | (work_neg & (work_bcd[BCD_W-1 -: 4] != 4'd0));
`else
  assign capture_mag = capture_raw;
  assign commit_ovf  = work_ovf;
`endif

  always_comb begin
    adj_bcd = work_bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (work_bcd[4*i +: 4] >= 4'd5)
        adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      pending_valid <= 1'b0;
      pending_value <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load)
            state <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (bit_cnt == CNT_W'(BINARY_WIDTH - 1))
            state <= ST_COMMIT;
          if (load) begin
            pending_valid <= 1'b1;
            pending_value <= display_integer;
          end
        end
        ST_COMMIT: begin
          pending_valid <= 1'b0;
          state         <= (load || pending_valid) ? ST_CONVERT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      work_bcd  <= '0;
      work_ovf  <= 1'b0;
      bit_cnt   <= '0;
`ifdef SIGNED_DISPLAY_EN
      work_neg  <= 1'b0;
`endif
    end else if (start) begin
      shift_reg <= capture_mag;
      work_bcd  <= '0;
      work_ovf  <= 1'b0;
      bit_cnt   <= '0;
`ifdef SIGNED_DISPLAY_EN
      work_neg  <= capture_neg;
`endif
    end else if (state == ST_CONVERT) begin
      work_bcd  <= {adj_bcd[BCD_W-2:0], shift_reg[BINARY_WIDTH-1]};
      shift_reg <= {shift_reg[BINARY_WIDTH-2:0], 1'b0};
      work_ovf  <= work_ovf | adj_bcd[BCD_W-1];
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  assign bcd_next = commit_now ? work_bcd : bcd_data;
  assign ovf_next = commit_now ? commit_ovf : overflow;
`ifdef SIGNED_DISPLAY_EN
  assign neg_next = commit_now ? work_neg : neg_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_data <= '0;
      overflow <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
      neg_reg  <= 1'b0;
`endif
    end else begin
      bcd_data <= bcd_next;
      overflow <= ovf_next;
`ifdef SIGNED_DISPLAY_EN
      neg_reg  <= neg_next;
`endif
    end
  end

  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIVIDER - 1));

  always_comb begin
    scan_idx_next = scan_idx;
    if (scan_wrap)
      scan_idx_next = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
  end

  // Rendered from next-state values so the registered glyph always agrees with the
  // enable and the committed result on the same edge.
  always_comb begin
    sel_pos   = 0;
    msd_pos   = 0;
    sel_digit = 4'd0;
    onehot    = '0;
    glyph     = 8'h00;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_next[4*i +: 4] != 4'd0)
        msd_pos = i;
      if (scan_idx_next == IDX_W'(i)) begin
        sel_pos   = i;
        sel_digit = bcd_next[4*i +: 4];
        onehot[i] = 1'b1;
      end
    end
    if (ovf_next)
      glyph = 8'h40;
    else if (sel_pos <= msd_pos)
      glyph = seven_seg(sel_digit);
`ifdef SIGNED_DISPLAY_EN
    else if (neg_next && (sel_pos == msd_pos + 1))
      glyph = 8'h40;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt          <= '0;
      scan_idx          <= '0;
      digit_change_tick <= 1'b0;
      segment_bits      <= SEG_IDLE;
      digit_enable      <= EN_IDLE;
    end else begin
      scan_cnt          <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      scan_idx          <= scan_idx_next;
      digit_change_tick <= scan_wrap;
      segment_bits      <= glyph ^ SEG_IDLE;
      digit_enable      <= onehot ^ EN_IDLE;
    end
  end

endmodule

// File: tb/tb_multi_digit_integer_display_controller.sv
// Randomized bench with a decimal-arithmetic reference model plus directed literal checks.
module tb_multi_digit_integer_display_controller;

  localparam int BW = 8;
  localparam int ND = 3;
  localparam int SD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [BW-1:0]   din  = '0;
  logic            load = 1'b0;
  logic            busy;
  logic [4*ND-1:0] bcd;
  logic            ovf;
  logic [7:0]      seg;
  logic [ND-1:0]   en;
  logic            tick;

  logic [BW-1:0]   din2  = '0;
  logic            load2 = 1'b0;
  logic            busy2;
  logic [7:0]      bcd2;
  logic            ovf2;
  logic [7:0]      seg2;
  logic [1:0]      en2;
  logic            tick2;

  int n_vec  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;

  logic [7:0] glyph_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [7:0] seen [ND];

  always #5 clk = ~clk;

  multi_digit_integer_display_controller #(
    .BINARY_WIDTH(BW), .NUM_DIGITS(ND), .SCAN_DIVIDER(SD), .ACTIVE_LOW_OUTPUTS(0)
  ) dut (
    .clk(clk), .reset_n(rst_n), .display_integer(din), .load(load), .busy(busy),
    .bcd_data(bcd), .overflow(ovf), .segment_bits(seg), .digit_enable(en),
    .digit_change_tick(tick)
  );

  multi_digit_integer_display_controller #(
    .BINARY_WIDTH(BW), .NUM_DIGITS(2), .SCAN_DIVIDER(SD), .ACTIVE_LOW_OUTPUTS(0)
  ) dut2 (
    .clk(clk), .reset_n(rst_n), .display_integer(din2), .load(load2), .busy(busy2),
    .bcd_data(bcd2), .overflow(ovf2), .segment_bits(seg2), .digit_enable(en2),
    .digit_change_tick(tick2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned pow10(input int n);
    int unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic void decode(input logic [BW-1:0] raw, input int nd,
                                 output int unsigned mag, output bit neg, output bit ov);
`ifdef SIGNED_DISPLAY_EN
    neg = raw[BW-1];
    mag = neg ? ((32'd1 << BW) - 32'(raw)) : 32'(raw);
    ov  = neg ? (mag >= pow10(nd - 1)) : (mag >= pow10(nd));
`else
    neg = 1'b0;
    mag = 32'(raw);
    ov  = (mag >= pow10(nd));
`endif
  endfunction

  function automatic logic [31:0] exp_bcd(input int unsigned mag, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++)
      r = r | (32'((mag / pow10(i)) % 10) << (4 * i));
    return r;
  endfunction

  function automatic logic [7:0] exp_glyph(input int unsigned mag, input bit neg,
                                           input bit ov, input int pos);
    int ndig = 1;
    if (ov) return 8'h40;
    while (ndig < 10 && mag >= pow10(ndig)) ndig++;
    if (pos < ndig) return glyph_tab[(mag / pow10(pos)) % 10];
    if (neg && pos == ndig) return 8'h40;
    return 8'h00;
  endfunction

  // Transaction-level model: a conversion finishes BW+1 edges after it starts.
  bit          m_busy, m_pend, m_valid, m_tick;
  int          m_left, m_cnt, m_idx;
  logic [BW-1:0] m_cur, m_pval, m_comm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_pend <= 0; m_valid <= 0; m_tick <= 0;
      m_left <= 0; m_cnt <= 0; m_idx <= 0;
      m_cur <= '0; m_pval <= '0; m_comm <= '0;
    end else begin
      m_valid <= 1;
      m_tick  <= (m_cnt == SD - 1);
      m_cnt   <= (m_cnt + 1) % SD;
      if (m_cnt == SD - 1) m_idx <= (m_idx + 1) % ND;
      if (!m_busy) begin
        if (load) begin m_busy <= 1; m_cur <= din; m_left <= BW + 1; end
      end else if (m_left == 1) begin
        m_comm <= m_cur;
        if (load) begin m_cur <= din; m_left <= BW + 1; m_pend <= 0; end
        else if (m_pend) begin m_cur <= m_pval; m_left <= BW + 1; m_pend <= 0; end
        else m_busy <= 0;
      end else begin
        m_left <= m_left - 1;
        if (load) begin m_pend <= 1; m_pval <= din; end
      end
    end
  end

  always @(negedge clk) begin : compare
    int unsigned mag;
    bit neg, ov;
    if (chk_en) begin
      decode(m_comm, ND, mag, neg, ov);
      check("busy", 32'(busy), 32'(m_busy));
      check("bcd_data", 32'(bcd), exp_bcd(mag, ND));
      check("overflow", 32'(ovf), 32'(ov));
      check("digit_change_tick", 32'(tick), 32'(m_tick));
      check("digit_enable", 32'(en), m_valid ? (32'd1 << m_idx) : 32'd0);
      check("segment_bits", 32'(seg), m_valid ? 32'(exp_glyph(mag, neg, ov, m_idx)) : 32'd0);
    end
  end

  task automatic load_val(input logic [BW-1:0] v);
    din  = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    din  = BW'($urandom);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 100) begin @(negedge clk); c++; end
    check("idle_within_bound", 32'(busy), 32'd0);
  endtask

  task automatic scan_collect();
    for (int i = 0; i < ND; i++) seen[i] = 8'hAA;
    repeat (ND * SD + 2) begin
      @(negedge clk);
      for (int i = 0; i < ND; i++) if (en[i]) seen[i] = seg;
    end
  endtask

  function automatic logic [BW-1:0] pick();
    logic [BW-1:0] specials [9] = '{8'd0, 8'd1, 8'd9, 8'd10, 8'd99, 8'd100, 8'd127, 8'd128, 8'd255};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 8)];
    return BW'($urandom);
  endfunction

  initial begin : stim
    logic [4*ND-1:0] q [$];
    logic [4*ND-1:0] prev;
    int cnt, drops;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_seg", 32'(seg), 32'h00);
    check("reset_en", 32'(en), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    check("first_edge_en", 32'(en), 32'b001);
    check("first_edge_seg", 32'(seg), 32'h3F);

`ifndef SIGNED_DISPLAY_EN
    load_val(8'd255);
    cnt = 0;
    while (busy && cnt < 60) begin cnt++; @(negedge clk); end
    check("busy_cycles_255", 32'(cnt), 32'd9);
    check("bcd_255", 32'(bcd), 32'h255);
    check("ovf_255", 32'(ovf), 32'd0);
    scan_collect();
    check("glyph_255_d0", 32'(seen[0]), 32'h6D);
    check("glyph_255_d1", 32'(seen[1]), 32'h6D);
    check("glyph_255_d2", 32'(seen[2]), 32'h5B);
`endif

    load_val(8'd7);
    wait_idle();
    check("bcd_7", 32'(bcd), 32'h007);
    scan_collect();
    check("glyph_7_d0", 32'(seen[0]), 32'h07);
    check("glyph_7_d1", 32'(seen[1]), 32'h00);
    check("glyph_7_d2", 32'(seen[2]), 32'h00);

    load_val(8'd10);
    load_val(8'd99);
    @(negedge clk);
    load_val(8'd42);
    prev  = bcd;
    drops = 0;
    for (int c = 0; c < 60 && q.size() < 2; c++) begin
      @(negedge clk);
      if (bcd != prev) begin q.push_back(bcd); prev = bcd; end
      else if (!busy) drops++;
    end
    check("pending_commit_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      check("pending_first", 32'(q[0]), 32'h010);
      check("pending_latest", 32'(q[1]), 32'h042);
    end
    check("busy_gap_between_commits", 32'(drops), 32'd0);
    wait_idle();

`ifdef SIGNED_DISPLAY_EN
    load_val(8'hF6);
    wait_idle();
    check("bcd_neg10", 32'(bcd), 32'h010);
    scan_collect();
    check("glyph_neg10_d0", 32'(seen[0]), 32'h3F);
    check("glyph_neg10_d1", 32'(seen[1]), 32'h06);
    check("glyph_neg10_d2", 32'(seen[2]), 32'h40);
`endif

    for (int c = 0; c < 500; c++) begin
      load = ($urandom_range(0, 3) == 0);
      din  = pick();
      @(negedge clk);
    end
    load = 1'b0;
    wait_idle();

    load_val(8'd77);
    wait_idle();
    load_val(8'd123);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_bcd", 32'(bcd), 32'd0);
    check("midreset_ovf", 32'(ovf), 32'd0);
    check("midreset_seg", 32'(seg), 32'h00);
    check("midreset_en", 32'(en), 32'd0);
    check("midreset_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_en", 32'(en), 32'b001);
    check("post_reset_seg", 32'(seg), 32'h3F);

    din2 = 8'd200; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    cnt = 0;
    while (busy2 && cnt < 60) begin cnt++; @(negedge clk); end
    check("nd2_idle", 32'(busy2), 32'd0);
    check("nd2_ovf_200", 32'(ovf2), 32'd1);
    for (int c = 0; c < 2 * SD + 1; c++) begin
      @(negedge clk);
      check("nd2_dash", 32'(seg2), 32'h40);
    end
    din2 = 8'd99; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    repeat (BW + 1) @(negedge clk);
    check("nd2_ovf_99", 32'(ovf2), 32'd0);
    check("nd2_bcd_99", 32'(bcd2), 32'h99);
    din2 = 8'd100; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    repeat (BW + 1) @(negedge clk);
    check("nd2_ovf_100", 32'(ovf2), 32'd1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_digit_integer_display_controller.md
# multi_digit_integer_display_controller

Parametrised successor of the fixed 8-bit/3-digit integer display path: converts a BINARY_WIDTH-bit integer to NUM_DIGITS BCD digits with an internal sequential double-dabble engine and multiplexes the result onto a common-segment seven-segment bank. Adds a load/busy handshake with a latest-value-wins pending slot, overflow indication, and leading-zero blanking. Sits between the classifier result register and the board display pins.

## Interface
- BINARY_WIDTH, 8: width of the input integer (2..32).
- NUM_DIGITS, 3: number of display digits (1..8).
- SCAN_DIVIDER, 50000: clk cycles each digit stays enabled (≥2).
- ACTIVE_LOW_OUTPUTS, 1: 1 inverts segment_bits and digit_enable at the pins.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- display_integer  in  BINARY_WIDTH  value to show; sampled only when load=1.
- load  in  1  request conversion of display_integer.
- busy  out  1  conversion in progress.
- bcd_data  out  4*NUM_DIGITS  committed BCD result; digit 0 in [3:0] (least significant).
- overflow  out  1  committed value does not fit in NUM_DIGITS digits.
- segment_bits  out  8  {dp,g,f,e,d,c,b,a} for the enabled digit; dp always off.
- digit_enable  out  NUM_DIGITS  one-hot digit select; bit 0 = least significant digit.
- digit_change_tick  out  1  one-cycle pulse when the scan advances.

## Operation
- FSM: IDLE, CONVERT, COMMIT.
- IDLE: load=1 captures display_integer into shift register, clears BCD work register and overflow flag → CONVERT.
- CONVERT: exactly BINARY_WIDTH cycles; each cycle adds 3 to every work digit ≥5, then shifts {bcd,bin} left by one. Any 1 shifted out of the top work digit sets the overflow flag. Then → COMMIT.
- COMMIT: bcd_data and overflow updated atomically in one cycle. If pending set: capture pending value, clear pending → CONVERT; else → IDLE.
- load=1 while busy: value stored in a single pending slot (later loads overwrite; latest wins). Never dropped, never queued deeper.
- Display reads only committed registers; never shows intermediate conversion state.
- Digit rendering: 0–9 standard glyphs. Digits above the most significant non-zero digit blank; committed value 0 shows "0" on digit 0 only. overflow=1: every digit shows "-" (segment g only).
- Scan counter counts 0..SCAN_DIVIDER-1; at terminal count pulses digit_change_tick and advances index, wrapping NUM_DIGITS-1 → 0.

## Timing
- Reset (async assert, sync release): state IDLE, pending cleared, busy=0, bcd_data=0, overflow=0, digit_change_tick=0, scan index 0, counter 0, segment_bits and digit_enable all inactive (0xFF / all-ones when ACTIVE_LOW_OUTPUTS=1).
- First edge after release: digit_enable selects digit 0 showing "0".
- load sampled at edge k in IDLE: busy=1 from after edge k, bcd_data/overflow valid and busy=0 after edge k+BINARY_WIDTH+1 (latency BINARY_WIDTH+1 cycles).
- Load pending at COMMIT: busy stays high continuously; next result BINARY_WIDTH+1 cycles after that commit.
- load in same cycle as COMMIT: goes to pending slot, serviced immediately.
- segment_bits/digit_enable registered; change on the same edge digit_change_tick rises; glyph always matches enabled digit (no ghost cycle).
- Reset mid-conversion: conversion and pending aborted, outputs return to reset values.

## Configuration
- SIGNED_DISPLAY_EN defined: display_integer is two's complement; magnitude converted; negative values show "-" on the digit immediately left of the most significant displayed digit; overflow when magnitude ≥ 10^(NUM_DIGITS-1) (negative) or ≥ 10^NUM_DIGITS (positive); -2^(BINARY_WIDTH-1) handled. bcd_data holds magnitude.
- Undefined: input unsigned, no sign logic synthesised.

## Test plan
(BINARY_WIDTH=8, NUM_DIGITS=3, SCAN_DIVIDER=4, ACTIVE_LOW_OUTPUTS=0.)
- load 255 → busy high 9 cycles, bcd_data=0x255, overflow=0; scan shows 5,5,2 on digits 0,1,2.
- load 7 → bcd_data=0x007; digits 1,2 segment_bits=0x00, digit 0 =0x07.
- NUM_DIGITS=2, load 200 → overflow=1, all digits 0x40.
- load 10, then load 99 and load 42 while busy → commits 0x010 then 0x042 back-to-back, busy never drops between; 99 never committed.
- reset_n low mid-CONVERT → outputs immediately reset values; after release, digit 0 shows 0x3F.
- SIGNED_DISPLAY_EN, load 8'hF6 (-10) → bcd_data=0x010, digit 2 = 0x40, digit 1 = 0x06, digit 0 = 0x3F.
